// File: rtl/rom_loader.sv
// Byte-stream program loader: parses a word-count header and data words, writes them to program
// memory, then releases the CPU. Define ROM_LOADER_CHECKSUM_EN to require a trailing XOR checksum.
module rom_loader #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            byte_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  start_i,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  cpu_run_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned CntW = ADDR_WIDTH + 1;

`ifdef ROM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StHdrLo = 3'd0, StHdrHi = 3'd1, StDatLo = 3'd2, StDatHi = 3'd3,
        StWrite = 3'd4, StChk = 3'd5, StDone = 3'd6, StErr = 3'd7
    } state_e;
`else
    typedef enum logic [2:0] {
        StHdrLo = 3'd0, StHdrHi = 3'd1, StDatLo = 3'd2, StDatHi = 3'd3,
        StWrite = 3'd4, StDone = 3'd6, StErr = 3'd7
    } state_e;
`endif

    state_e          state_q;
    logic [15:0]     count_q;
    logic [CntW-1:0] word_cnt_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]      csum_q;
`endif

    logic        xfer;
    logic [16:0] hdr_n;
    logic [16:0] hdr_max;
    logic        last_word;

    assign xfer      = valid_i & ready_o;
    // Full count as it will be once the high header byte lands this cycle
    assign hdr_n     = {1'b0, byte_i, count_q[7:0]};
    assign hdr_max   = 17'd1 << ADDR_WIDTH;
    assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, count_q};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StHdrLo;
            ready_o    <= 1'b1;
            mem_wr_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            cpu_run_o  <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            count_q    <= '0;
            word_cnt_q <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            mem_wr_o <= 1'b0;
            case (state_q)
                StHdrLo: begin
                    if (xfer) begin
                        count_q[7:0] <= byte_i;
                        state_q      <= StHdrHi;
                    end
                end
                StHdrHi: begin
                    if (xfer) begin
                        count_q[15:8] <= byte_i;
                        if (hdr_n == 17'd0 || hdr_n > hdr_max) begin
                            state_q <= StErr;
                            ready_o <= 1'b0;
                            err_o   <= 1'b1;
                        end else begin
                            state_q <= StDatLo;
                        end
                    end
                end
                StDatLo: begin
                    if (xfer) begin
                        mem_data_o[7:0] <= byte_i;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ byte_i;
`endif
                        state_q <= StDatHi;
                    end
                end
                StDatHi: begin
                    if (xfer) begin
                        mem_data_o[15:8] <= byte_i;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ byte_i;
`endif
                        state_q  <= StWrite;
                        ready_o  <= 1'b0;
                        mem_wr_o <= 1'b1;
                    end
                end
                StWrite: begin
                    mem_addr_o <= mem_addr_o + ADDR_WIDTH'(1);
                    word_cnt_q <= word_cnt_q + CntW'(1);
                    if (last_word) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        state_q <= StChk;
                        ready_o <= 1'b1;
`else
                        state_q   <= StDone;
                        cpu_run_o <= 1'b1;
                        done_o    <= 1'b1;
`endif
                    end else begin
                        state_q <= StDatLo;
                        ready_o <= 1'b1;
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                StChk: begin
                    if (xfer) begin
                        ready_o <= 1'b0;
                        if (byte_i == csum_q) begin
                            state_q   <= StDone;
                            cpu_run_o <= 1'b1;
                            done_o    <= 1'b1;
                        end else begin
                            state_q <= StErr;
                            err_o   <= 1'b1;
                        end
                    end
                end
`endif
                StDone, StErr: begin
                    if (start_i) begin
                        state_q    <= StHdrLo;
                        ready_o    <= 1'b1;
                        cpu_run_o  <= 1'b0;
                        done_o     <= 1'b0;
                        err_o      <= 1'b0;
                        mem_addr_o <= '0;
                        word_cnt_q <= '0;
                        count_q    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= StHdrLo;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
